// File: rtl/model_pkg.sv
// Shared constants and helpers for the Gray-to-binary converter.
// Holds the default width and a width-generic Gray-to-binary function.
package model_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // A zero-extended Gray word converts correctly through the full
  // 32-bit prefix XOR, so callers pass 32'(gray) and truncate back.
  function automatic logic [31:0] g2b(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/model_g2b_core.sv
// Combinational Gray-to-binary conversion core.
// Ports: gray_i (Gray word), bin_o (binary equivalent, zero latency).
module model_g2b_core
  import model_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  assign bin_o = WIDTH'(g2b(32'(gray_i)));

endmodule

// File: rtl/model.sv
// Gray-to-binary converter with registered result and step checking.
// Ports: clk, rst_n (async, active-low), gray, in_valid -> bin (comb),
//   bin_q, out_valid, step_up, step_dn, step_err (registered).
// MODEL_STEP_CHECK_EN enables the step flags; otherwise they are tied 0.
module model
  import model_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray,
  input  logic             in_valid,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] bin_q,
  output logic             out_valid,
  output logic             step_up,
  output logic             step_dn,
  output logic             step_err
);

  logic [WIDTH-1:0] hold_q;
  logic             vld_q;

  model_g2b_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .gray_i (gray),
    .bin_o  (bin)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) hold_q <= bin;
    end
  end

  assign bin_q     = hold_q;
  assign out_valid = vld_q;

`ifdef MODEL_STEP_CHECK_EN
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] prev_bin;
  logic [WIDTH-1:0] diff;
  logic             seen_q;
  logic             multi;
  logic             up_d, dn_d, err_d;
  logic             up_q, dn_q, err_q;

  assign prev_bin = WIDTH'(g2b(32'(prev_q)));
  assign diff     = gray ^ prev_q;
  // More than one bit set: clearing the lowest set bit leaves residue.
  assign multi    = |(diff & (diff - WIDTH'(1)));

  assign err_d = seen_q & multi;
  assign up_d  = seen_q & ~multi & (bin == prev_bin + WIDTH'(1));
  assign dn_d  = seen_q & ~multi & (bin == prev_bin - WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      seen_q <= 1'b0;
      up_q   <= 1'b0;
      dn_q   <= 1'b0;
      err_q  <= 1'b0;
    end else if (in_valid) begin
      prev_q <= gray;
      seen_q <= 1'b1;
      up_q   <= up_d;
      dn_q   <= dn_d;
      err_q  <= err_d;
    end else begin
      up_q  <= 1'b0;
      dn_q  <= 1'b0;
      err_q <= 1'b0;
    end
  end

  assign step_up  = up_q;
  assign step_dn  = dn_q;
  assign step_err = err_q;
`else
  assign step_up  = 1'b0;
  assign step_dn  = 1'b0;
  assign step_err = 1'b0;
`endif

endmodule

// File: tb/tb_model.sv
// Self-checking bench for model: directed cases plus random stream
// compared against a behavioural reference model.
module tb_model;

`ifdef MODEL_STEP_CHECK_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] gray;
  logic       in_valid;
  logic [7:0] bin, bin_q;
  logic       out_valid, step_up, step_dn, step_err;

  int total = 0;
  int bad   = 0;

  // reference state
  logic [7:0] m_binq, m_pg;
  logic       m_ov, m_up, m_dn, m_err, m_seen;

  model #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gray      (gray),
    .in_valid  (in_valid),
    .bin       (bin),
    .bin_q     (bin_q),
    .out_valid (out_valid),
    .step_up   (step_up),
    .step_dn   (step_dn),
    .step_err  (step_err)
  );

  always #5 clk = ~clk;

  // binary value whose Gray encoding is g, found by search
  function automatic logic [7:0] ref_bin(input logic [7:0] g);
    logic [7:0] vv;
    for (int v = 0; v < 256; v++) begin
      vv = 8'(v);
      if ((vv ^ (vv >> 1)) == g) return vv;
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] to_gray(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_binq = 0; m_pg = 0; m_ov = 0;
    m_up = 0; m_dn = 0; m_err = 0; m_seen = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".bin_q"}, 32'(bin_q), 32'(m_binq));
    chk({tag, ".ov"}, 32'(out_valid), 32'(m_ov));
    chk({tag, ".up"}, 32'(step_up), 32'(m_up));
    chk({tag, ".dn"}, 32'(step_dn), 32'(m_dn));
    chk({tag, ".err"}, 32'(step_err), 32'(m_err));
  endtask

  task automatic step(input string tag, input logic v,
                      input logic [7:0] g);
    logic [7:0] b, pb;
    @(negedge clk);
    in_valid = v;
    gray     = g;
    #1;
    b = ref_bin(g);
    chk({tag, ".bin"}, 32'(bin), 32'(b));
    m_ov = v;
    if (v) begin
      pb = ref_bin(m_pg);
      if (m_seen && EN) begin
        m_err = ($countones(g ^ m_pg) > 1);
        m_up  = !m_err && (b == 8'(pb + 8'd1));
        m_dn  = !m_err && (b == 8'(pb - 8'd1));
      end else begin
        m_up = 0; m_dn = 0; m_err = 0;
      end
      m_binq = b;
      m_pg   = g;
      m_seen = 1;
    end else begin
      m_up = 0; m_dn = 0; m_err = 0;
    end
    @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  initial begin
    logic [7:0] cur_b, nb;
    int kind;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    gray     = 8'h00;
    model_reset();
    #1;
    chk("comb_00", 32'(bin), 32'h00);
    gray = 8'h03; #1;
    chk("comb_03", 32'(bin), 32'h02);
    gray = 8'h06; #1;
    chk("comb_06", 32'(bin), 32'h04);
    gray = 8'h80; #1;
    chk("comb_80", 32'(bin), 32'hFF);
    @(posedge clk); #1;
    check_regs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    step("s33a", 1'b1, 8'h00);
    chk("s33a_up", 32'(step_up), 32'h0);
    step("s33b", 1'b1, 8'h01);
    chk("s33b_q", 32'(bin_q), 32'h01);
    chk("s33b_up", 32'(step_up), 32'(EN));
    step("s33c", 1'b1, 8'h03);
    chk("s33c_q", 32'(bin_q), 32'h02);
    chk("s33c_up", 32'(step_up), 32'(EN));

    step("s34a", 1'b1, 8'h80);
    chk("s34a_q", 32'(bin_q), 32'hFF);
    step("s34b", 1'b1, 8'h00);
    chk("s34b_q", 32'(bin_q), 32'h00);
    chk("s34b_up", 32'(step_up), 32'(EN));
    step("s34c", 1'b1, 8'h03);
    chk("s34c_err", 32'(step_err), 32'(EN));
    chk("s34c_up", 32'(step_up), 32'h0);
    step("dnwrap", 1'b1, 8'h00);
    step("dnwrap2", 1'b1, 8'h80);
    chk("dnwrap_dn", 32'(step_dn), 32'(EN));
    step("same", 1'b1, 8'h80);
    step("idle", 1'b0, 8'h55);
    chk("idle_q", 32'(bin_q), 32'hFF);

    // mid-stream asynchronous reset
    step("pre_rst", 1'b1, 8'hC0);
    @(negedge clk);
    in_valid = 1'b1;
    gray     = 8'h40;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_regs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 1'b1, 8'h41);

    // random stream biased toward single steps
    cur_b = ref_bin(8'h41);
    for (int i = 0; i < 400; i++) begin
      kind = int'($urandom_range(0, 5));
      case (kind)
        0, 1:    nb = cur_b + 8'd1;
        2, 3:    nb = cur_b - 8'd1;
        4:       nb = cur_b;
        default: nb = 8'($urandom);
      endcase
      if ($urandom_range(0, 4) == 0) begin
        step("rnd_idle", 1'b0, 8'($urandom));
      end else begin
        step("rnd", 1'b1, to_gray(nb));
        cur_b = nb;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL timeout total=%0d", total);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/model.md
MODEL -- requirements
Module: model

Interface
REQ-001 Parameter WIDTH, default 8: bit width of the Gray input and all binary outputs; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock for all registered outputs.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 gray  input  WIDTH  Gray-coded value.
REQ-005 in_valid  input  1  qualifies gray for the registered path.
REQ-006 bin  output  WIDTH  combinational binary equivalent of gray.
REQ-007 bin_q  output  WIDTH  registered binary value of the last valid gray.
REQ-008 out_valid  output  1  registered; high one cycle after each accepted in_valid.
REQ-009 step_up  output  1  registered; valid sample's binary equals the previous valid sample's binary plus 1, modulo 2^WIDTH.
REQ-010 step_dn  output  1  registered; valid sample's binary equals the previous valid sample's binary minus 1, modulo 2^WIDTH.
REQ-011 step_err  output  1  registered; consecutive valid gray samples differ in more than one bit.

Function
REQ-012 bin[WIDTH-1] SHALL equal gray[WIDTH-1].
REQ-013 For i from WIDTH-2 down to 0, bin[i] SHALL equal bin[i+1] XOR gray[i].
REQ-014 bin is purely combinational: zero latency, independent of clk, rst_n and in_valid, valid with clk and rst_n left undriven.
REQ-015 Accept on a rising clk edge with in_valid=1:
- bin_q <= bin.
- out_valid <= 1.
- Previous-sample register <= gray.
REQ-016 A rising edge with in_valid=0:
- out_valid <= 0.
- bin_q holds its value.
- step_up, step_dn and step_err <= 0.
REQ-017 The step flags SHALL be computed only when a previous valid sample exists (first-sample flag set); the first accepted sample after reset drives all three to 0.
REQ-018 Equal consecutive gray samples (zero bits differ) SHALL drive all step flags to 0.
REQ-019 Wrap-around counts as a step:
- previous bin all-ones, new bin 0 -> step_up=1.
- previous bin 0, new bin all-ones -> step_dn=1.
REQ-020 step_up and step_dn SHALL never be 1 together.
REQ-021 The step flags are mutually exclusive with step_err; step_err=1 forces step_up=step_dn=0.

Reset
REQ-022 rst_n=0 SHALL immediately clear bin_q, out_valid, step_up, step_dn, step_err, the previous-sample register and the first-sample flag.
REQ-023 The reset clear applies even mid-stream, without waiting for clk.
REQ-024 After rst_n deasserts, the first accepted sample is treated as the first after reset (REQ-017).

Configuration
REQ-025 Macro MODEL_STEP_CHECK_EN defined: step_up, step_dn and step_err SHALL behave per REQ-009 to REQ-011 and REQ-016 to REQ-021.
REQ-026 Macro MODEL_STEP_CHECK_EN undefined:
- step_up, step_dn and step_err tied to 0.
- Previous-sample register and first-sample flag absent.
- bin, bin_q and out_valid unchanged.

Structure
REQ-027 Package model_pkg SHALL hold the default width constant and a WIDTH-generic Gray-to-binary function.
REQ-028 Sub-module model_g2b_core SHALL implement the combinational conversion.
REQ-029 model SHALL instantiate model_g2b_core once, feeding both bin and the bin_q register.

Verification
REQ-030 WIDTH=8, gray=0x00 -> bin=0x00 within 1 ns.
REQ-031 gray=0x03 -> bin=0x02.
REQ-032 gray=0x06 -> bin=0x04; also check gray=0x80 -> bin=0xFF.
REQ-033 Reset, then valid gray sequence 0x00, 0x01, 0x03:
- out_valid=1 each following cycle.
- bin_q sequence 0x00, 0x01, 0x02.
- step_up=0, then 1, then 1.
REQ-034 Valid gray 0x80 then 0x00:
- bin_q 0xFF then 0x00.
- step_up=1 on the second sample (wrap).
- Then valid gray 0x03 (from 0x00, two bits differ) -> step_err=1, step_up=step_dn=0.
REQ-035 Assert rst_n=0 mid-stream with in_valid=1:
- All registered outputs 0 before the next clk edge.
- First sample after release gives step_up=step_dn=step_err=0.
